conv_sched: RTL and testbench

CONV_SCHED -- requirements
Module: conv_sched

---
 rtl/conv_sched_if.sv | 44 ++++
 rtl/conv_sched.sv | 152 +++++++++++++++
 tb/tb_conv_sched.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_sched_if.sv
// conv_sched_if -- handshake bundle between the convolution pass scheduler,
// its window generator and the accumulator.
//
// Signals (slave = scheduler side):
//   start       in   layer start request
//   abort       in   synchronous abort of the current layer
//   gen_beat    in   window generator produced one map beat
//   acc_ready   in   accumulator can accept a pass flush
//   gen_start   out  one-cycle launch pulse to the window generator
//   acc_flush   out  one-cycle pass-complete pulse to the accumulator
//   group_idx   out  current filter group (pass) index
//   weight_base out  group_idx*WEIGHT_NUM, first weight word of the group
//   busy        out  scheduler is not idle
//   done        out  one-cycle layer completion pulse
//   err_beat    out  sticky flag: a beat arrived outside the run phase
interface conv_sched_if #(
  parameter int GROUP_NUM  = 4,
  parameter int WEIGHT_NUM = 25
);
  localparam int GW = (GROUP_NUM > 1) ? $clog2(GROUP_NUM) : 1;
  localparam int WW = (GROUP_NUM * WEIGHT_NUM > 1) ? $clog2(GROUP_NUM * WEIGHT_NUM) : 1;

  logic          start;
  logic          abort;
  logic          gen_beat;
  logic          acc_ready;
  logic          gen_start;
  logic          acc_flush;
  logic [GW-1:0] group_idx;
  logic [WW-1:0] weight_base;
  logic          busy;
  logic          done;
  logic          err_beat;

  modport slave (
    input  start, abort, gen_beat, acc_ready,
    output gen_start, acc_flush, group_idx, weight_base, busy, done, err_beat
  );

  modport master (
    output start, abort, gen_beat, acc_ready,
    input  gen_start, acc_flush, group_idx, weight_base, busy, done, err_beat
  );
endinterface

// File: rtl/conv_sched.sv
// conv_sched -- sequences one convolution layer as GROUP_NUM passes. Each pass
// launches the window generator, counts WIN_H*WIN_L*FILTER_SIZE^2 map beats,
// waits DRAIN_CYC cycles for the fetch pipeline to empty, then hands a flush
// to the accumulator. After the last group the layer completes with done.
//
// Ports:
//   clk_in  clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     conv_sched_if.slave handshake bundle (see conv_sched_if.sv)
module conv_sched #(
  parameter int FILTER_SIZE = 5,
  parameter int WIN_H       = 62,
  parameter int WIN_L       = 24,
  parameter int GROUP_NUM   = 4,
  parameter int WEIGHT_NUM  = 25,
  parameter int BEAT_W      = 16,
  parameter int DRAIN_CYC   = 2
) (
  input  logic         clk_in,
  input  logic         rst_n,
  conv_sched_if.slave  bus
);
  localparam int BEATS = WIN_H * WIN_L * FILTER_SIZE * FILTER_SIZE;
  localparam int GW    = (GROUP_NUM > 1) ? $clog2(GROUP_NUM) : 1;
  localparam int WW    = (GROUP_NUM * WEIGHT_NUM > 1) ? $clog2(GROUP_NUM * WEIGHT_NUM) : 1;
  localparam int DW    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_RUN, S_DRAIN, S_FLUSH, S_FIN
  } state_t;

  state_t              state, state_nxt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [DW-1:0]       drain_cnt;
  logic [GW-1:0]       group_idx;
  logic [WW-1:0]       weight_base;
  logic                err_beat;

  logic clr_beat, inc_beat, clr_drain, inc_drain;
  logic clr_group, adv_group, set_err, clr_err;

  // State register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath control. Abort outranks every state transition
  // and also masks the pulse outputs below in the same cycle.
  always_comb begin
    state_nxt = state;
    clr_beat  = 1'b0;
    inc_beat  = 1'b0;
    clr_drain = 1'b0;
    inc_drain = 1'b0;
    clr_group = 1'b0;
    adv_group = 1'b0;
    clr_err   = 1'b0;
    set_err   = bus.gen_beat && (state != S_RUN);

    if (state != S_IDLE && bus.abort) begin
      state_nxt = S_IDLE;
      clr_beat  = 1'b1;
      clr_drain = 1'b1;
      clr_group = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state_nxt = S_LAUNCH;
            clr_beat  = 1'b1;
            clr_group = 1'b1;
            clr_err   = 1'b1;
          end
        end
        S_LAUNCH: begin
          state_nxt = S_RUN;
          clr_beat  = 1'b1;
        end
        S_RUN: begin
          if (bus.gen_beat) begin
            inc_beat = 1'b1;
            if (beat_cnt == BEAT_W'(BEATS - 1)) begin
              state_nxt = S_DRAIN;
              clr_drain = 1'b1;
            end
          end
        end
        S_DRAIN: begin
          inc_drain = 1'b1;
          if (drain_cnt == DW'(DRAIN_CYC - 1)) state_nxt = S_FLUSH;
        end
        S_FLUSH: begin
          if (bus.acc_ready) begin
            if (group_idx != GW'(GROUP_NUM - 1)) begin
              adv_group = 1'b1;
              state_nxt = S_LAUNCH;
            end else begin
              state_nxt = S_FIN;
            end
          end
        end
        S_FIN: begin
          state_nxt = S_IDLE;
          clr_group = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Counters, group index and the incrementally built weight base. The
  // weight base tracks group_idx by adding WEIGHT_NUM per pass so no
  // multiplier is needed. A stray beat in the same cycle as an accepted
  // start still leaves err_beat set.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      drain_cnt   <= '0;
      group_idx   <= '0;
      weight_base <= '0;
      err_beat    <= 1'b0;
    end else begin
      if (clr_beat)      beat_cnt <= '0;
      else if (inc_beat) beat_cnt <= beat_cnt + BEAT_W'(1);

      if (clr_drain)      drain_cnt <= '0;
      else if (inc_drain) drain_cnt <= drain_cnt + DW'(1);

      if (clr_group) begin
        group_idx   <= '0;
        weight_base <= '0;
      end else if (adv_group) begin
        group_idx   <= group_idx + GW'(1);
        weight_base <= weight_base + WW'(WEIGHT_NUM);
      end

      if (clr_err) err_beat <= 1'b0;
      if (set_err) err_beat <= 1'b1;
    end
  end

  // Pulses decode the registered state; the FLUSH pulse additionally
  // needs the accumulator handshake, and abort masks all three.
  assign bus.gen_start   = (state == S_LAUNCH) && !bus.abort;
  assign bus.acc_flush   = (state == S_FLUSH) && bus.acc_ready && !bus.abort;
  assign bus.done        = (state == S_FIN) && !bus.abort;
  assign bus.busy        = (state != S_IDLE);
  assign bus.group_idx   = group_idx;
  assign bus.weight_base = weight_base;
  assign bus.err_beat    = err_beat;
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched -- scoreboard bench for conv_sched. The driver walks through
// whole layers, deciding when beats, stalls, aborts and resets happen; from
// those decisions it derives the cycle at which each gen_start, acc_flush and
// done must appear and queues them. A monitor pops the queue whenever the DUT
// shows one of those pulses.
module tb_conv_sched;
  localparam int FILTER_SIZE = 2;
  localparam int WIN_H       = 2;
  localparam int WIN_L       = 2;
  localparam int GROUP_NUM   = 2;
  localparam int WEIGHT_NUM  = 4;
  localparam int BEAT_W      = 16;
  localparam int DRAIN_CYC   = 2;
  localparam int BEATS       = FILTER_SIZE * FILTER_SIZE * WIN_H * WIN_L;

  typedef enum int {EV_GEN, EV_FLUSH, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       grp;
  } ev_t;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  ev_t  mon_e;
  ev_kind_t mon_k;

  conv_sched_if #(.GROUP_NUM(GROUP_NUM), .WEIGHT_NUM(WEIGHT_NUM)) bus();

  conv_sched #(
    .FILTER_SIZE(FILTER_SIZE), .WIN_H(WIN_H), .WIN_L(WIN_L),
    .GROUP_NUM(GROUP_NUM), .WEIGHT_NUM(WEIGHT_NUM),
    .BEAT_W(BEAT_W), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  // Free-running cycle number used to timestamp expected pulses.
  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: every pulse must match the head of the scoreboard in kind,
  // cycle, group and weight base.
  always @(negedge clk_in) begin
    if (rst_n && (bus.gen_start || bus.acc_flush || bus.done)) begin
      checks++;
      if (int'(bus.gen_start) + int'(bus.acc_flush) + int'(bus.done) > 1) begin
        errors++;
        $display("[TB] FAIL pulse_exclusive: gen_start=%0b acc_flush=%0b done=%0b at cycle %0d, expected at most one",
                 bus.gen_start, bus.acc_flush, bus.done, cyc);
      end
      mon_k = bus.gen_start ? EV_GEN : (bus.acc_flush ? EV_FLUSH : EV_DONE);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_pulse: got %s at cycle %0d, expected none", mon_k.name(), cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_k != mon_e.kind) begin
          errors++;
          $display("[TB] FAIL pulse_kind: got %s, expected %s", mon_k.name(), mon_e.kind.name());
        end
        checks++;
        if (cyc != mon_e.cyc) begin
          errors++;
          $display("[TB] FAIL pulse_cycle(%s): got %0d, expected %0d", mon_e.kind.name(), cyc, mon_e.cyc);
        end
        if (mon_e.kind != EV_DONE) begin
          checks++;
          if (int'(bus.group_idx) != mon_e.grp) begin
            errors++;
            $display("[TB] FAIL group_idx(%s): got %0d, expected %0d", mon_e.kind.name(), bus.group_idx, mon_e.grp);
          end
          checks++;
          if (int'(bus.weight_base) != mon_e.grp * WEIGHT_NUM) begin
            errors++;
            $display("[TB] FAIL weight_base(%s): got %0d, expected %0d", mon_e.kind.name(), bus.weight_base, mon_e.grp * WEIGHT_NUM);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One layer. gap: 0 = random beats, 1 = continuous after one cycle of
  // generator latency, N = one beat every Nth cycle. stall: flush wait in
  // cycles (negative = random 0..6). abort_pass/abort_beat: abort after that
  // many beats of that pass (-1 = never). err_drain: stray beat in DRAIN of
  // pass 0. rst_flush: reset while the last pass sits in FLUSH.
  task automatic applyStimulus(input int gap, input int stall, input int abort_pass,
                               input int abort_beat, input bit err_drain, input bit rst_flush);
    int n, c, tl, k, fl;
    bit gb;
    bus.start = 1'b1;
    exp_q.push_back('{EV_GEN, cyc + 1, 0});
    tick;
    bus.start = 1'b0;
    checkOutput("busy_launch", int'(bus.busy), 1);
    checkOutput("err_beat_cleared_by_start", int'(bus.err_beat), 0);
    for (int g = 0; g < GROUP_NUM; g++) begin
      tick;
      n = 0;
      c = 0;
      while (n < BEATS) begin
        if (g == abort_pass && n == abort_beat) begin
          bus.abort    = 1'b1;
          bus.gen_beat = 1'b0;
          bus.start    = 1'b0;
          tick;
          bus.abort = 1'b0;
          checkOutput("busy_after_abort", int'(bus.busy), 0);
          tick;
          checkOutput("group_idx_after_abort", int'(bus.group_idx), 0);
          return;
        end
        c++;
        if (gap == 0) gb = 1'($urandom_range(0, 1));
        else if (gap == 1) gb = (c > 1);
        else gb = (c % gap == 0);
        bus.start    = 1'($urandom_range(0, 1));
        bus.gen_beat = gb;
        if (gb) n++;
        tick;
      end
      bus.gen_beat = 1'b0;
      bus.start    = 1'b0;
      tl = cyc - 1;
      if (err_drain && g == 0) begin
        bus.gen_beat = 1'b1;
        tick;
        bus.gen_beat = 1'b0;
        checkOutput("err_beat_in_drain", int'(bus.err_beat), 1);
      end
      if (rst_flush && g == GROUP_NUM - 1) begin
        while (cyc < tl + 1 + DRAIN_CYC) tick;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_gen_start", int'(bus.gen_start), 0);
        checkOutput("rst_acc_flush", int'(bus.acc_flush), 0);
        checkOutput("rst_done", int'(bus.done), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_group_idx", int'(bus.group_idx), 0);
        checkOutput("rst_weight_base", int'(bus.weight_base), 0);
        tick;
        rst_n = 1'b1;
        tick;
        checkOutput("busy_after_reset_release", int'(bus.busy), 0);
        return;
      end
      k  = (stall >= 0) ? stall : $urandom_range(0, 6);
      fl = tl + 1 + DRAIN_CYC + k;
      while (cyc < fl) tick;
      bus.acc_ready = 1'b1;
      exp_q.push_back('{EV_FLUSH, fl, g});
      if (g < GROUP_NUM - 1) exp_q.push_back('{EV_GEN, fl + 1, g + 1});
      else                   exp_q.push_back('{EV_DONE, fl + 1, g});
      tick;
      bus.acc_ready = 1'b0;
    end
    tick;
    checkOutput("busy_after_done", int'(bus.busy), 0);
    checkOutput("group_idx_after_done", int'(bus.group_idx), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not end, expected finish within budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.gen_beat  = 1'b0;
    bus.acc_ready = 1'b0;
    repeat (3) tick;
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_err_beat", int'(bus.err_beat), 0);
    checkOutput("reset_group_idx", int'(bus.group_idx), 0);
    checkOutput("reset_weight_base", int'(bus.weight_base), 0);
    rst_n = 1'b1;
    tick;

    $display("[TB] continuous beats, accumulator always ready");
    applyStimulus(1, 0, -1, 0, 1'b0, 1'b0);

    $display("[TB] accumulator stalls 5 cycles");
    applyStimulus(1, 5, -1, 0, 1'b0, 1'b0);

    $display("[TB] sparse beats, every third cycle");
    applyStimulus(3, 0, -1, 0, 1'b0, 1'b0);

    $display("[TB] stray beats in IDLE and DRAIN");
    bus.gen_beat = 1'b1;
    tick;
    bus.gen_beat = 1'b0;
    checkOutput("err_beat_in_idle", int'(bus.err_beat), 1);
    tick;
    checkOutput("err_beat_sticky", int'(bus.err_beat), 1);
    applyStimulus(1, -1, -1, 0, 1'b1, 1'b0);
    checkOutput("err_beat_sticky_after_layer", int'(bus.err_beat), 1);

    $display("[TB] abort and start together in IDLE");
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    checkOutput("abort_beats_start", int'(bus.busy), 0);
    tick;

    $display("[TB] abort at beat 7 of pass 1, then restart");
    applyStimulus(1, 0, 1, 7, 1'b0, 1'b0);
    applyStimulus(0, -1, -1, 0, 1'b0, 1'b0);

    $display("[TB] reset during FLUSH, then restart");
    applyStimulus(0, -1, -1, 0, 1'b0, 1'b1);
    applyStimulus(0, -1, -1, 0, 1'b0, 1'b0);

    $display("[TB] random layers");
    for (int i = 0; i < 4; i++) applyStimulus(0, -1, -1, 0, 1'b0, 1'b0);

    repeat (3) tick;
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
